// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
//
// Contents:
//   MULDIV_DIV_STEPS   : restoring-divide iteration count (equals XLEN)
//   muldiv_state_type  : sequencer FSM states
//   muldiv_op_type     : funct3 encodings of the M extension
//   helper functions   : op classification, magnitude, divide result fix-up
package muldiv_sequencer_pkg;

  localparam int XLEN             = 32;
  localparam int MULDIV_DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_type;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_type;

  // funct3[2] splits the multiply family from the divide family.
  function automatic logic op_is_div(input muldiv_op_type op);
    return op[2];
  endfunction

  // DIV and REM are the signed divide ops.
  function automatic logic op_div_signed(input muldiv_op_type op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // DIV and DIVU return the quotient; REM and REMU the remainder.
  function automatic logic op_div_quot(input muldiv_op_type op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // MULH and MULHSU treat rs1 as signed.
  function automatic logic op_mul_a_signed(input muldiv_op_type op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // Only MULH treats rs2 as signed.
  function automatic logic op_mul_b_signed(input muldiv_op_type op);
    return (op == OP_MULH);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  // Most-negative / -1 on a signed divide: the only case whose true
  // quotient does not fit in XLEN bits.
  function automatic logic div_overflow(input muldiv_op_type   op,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    return op_div_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  endfunction

  // Cases whose result is fixed without needing the iterations.
  function automatic logic div_special(input muldiv_op_type   op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    return (b == '0) || div_overflow(op, a, b);
  endfunction

  // Turns the unsigned quotient/remainder of the magnitudes into the
  // architectural result, including the divide-by-zero and overflow values.
  function automatic logic [XLEN-1:0] div_finish(input muldiv_op_type   op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r);
    logic [XLEN-1:0] res;
    if (b == '0) begin
      res = op_div_quot(op) ? '1 : a;
    end else if (div_overflow(op, a, b)) begin
      res = op_div_quot(op) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end else if (op_div_quot(op)) begin
      res = (op_div_signed(op) && (a[XLEN-1] ^ b[XLEN-1])) ? (~q + 1'b1) : q;
    end else begin
      // Remainder follows the sign of the dividend.
      res = (op_div_signed(op) && a[XLEN-1]) ? (~r + 1'b1) : r;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the mul/div sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the sequencer back to the pipeline.
//
// Signals:
//   start  : M-extension instruction valid in execute (held while stalled)
//   funct3 : operation select
//   op_a   : rs1 after forwarding
//   op_b   : rs2 after forwarding
//   flush  : kill the in-flight operation
//   stall  : freeze the pipeline at and before execute
//   done   : one-cycle pulse, result valid
//   result : operation result, held until the next completion
interface muldiv_sequencer_if;

  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  // Pipeline side.
  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, done, result
  );

  // Sequencer side.
  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, done, result
  );

endinterface

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring divide iteration (purely combinational).
// Latency: 0 cycles; the sequencer registers the outputs each step.
// Backpressure: none.
//
// Ports:
//   rem_i / quo_i : partial remainder and shifting dividend/quotient
//   dvsr_i        : divisor magnitude
//   rem_o / quo_o : updated remainder and quotient
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         fits;

  always_comb begin
    // The dividend bits are shifted out of the top of quo while quotient
    // bits enter at the bottom, so one register serves both roles.
    shifted = {rem_i, quo_i[W-1]};
    fits    = (shifted >= {1'b0, dvsr_i});
    // When fits is set the difference is below the divisor, so W bits hold it.
    diff    = shifted[W-1:0] - dvsr_i;
    rem_o   = fits ? diff : shifted[W-1:0];
    quo_o   = {quo_i[W-2:0], fits};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide controller: registered multiply, 32-step restoring divide.
// Latency: MUL family 2 cycles, divide family DIV_STEPS+1 (1 for special cases
// when MULDIV_EARLY_OUT_EN is defined). Backpressure: stall held until done.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : muldiv_sequencer_if.slave (start/funct3/op_a/op_b/flush in,
//           stall/done/result out)
// Build option:
//   MULDIV_EARLY_OUT_EN : divide-by-zero and signed overflow skip the iterations
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DIV_STEPS = MULDIV_DIV_STEPS
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  muldiv_state_type  state_q, state_d;
  muldiv_op_type     op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quo;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  muldiv_op_type     op_in;
  logic              in_signed;
  logic              stall;
  logic              done;

  muldiv_div_step #(
    .W(XLEN)
  ) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Multiply on the captured operands. A 64x64 product truncated to 64 bits
  // gives the correct signed, unsigned and mixed results once the operands
  // are extended according to the op.
  always_comb begin
    a_ext   = op_mul_a_signed(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    b_ext   = op_mul_b_signed(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    op_in     = muldiv_op_type'(bus.funct3);
    in_signed = op_div_signed(op_in);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall    = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          stall  = 1'b1;
          op_d   = op_in;
          a_d    = bus.op_a;
          b_d    = bus.op_b;
          rem_d  = '0;
          quo_d  = magnitude(bus.op_a, in_signed);
          dvsr_d = magnitude(bus.op_b, in_signed);
          cnt_d  = CNT_W'(DIV_STEPS);
          if (!op_is_div(op_in)) begin
            state_d = MUL;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            if (div_special(op_in, bus.op_a, bus.op_b)) begin
              state_d  = DONE;
              result_d = div_finish(op_in, bus.op_a, bus.op_b, '0, '0);
            end else begin
              state_d = DIV;
            end
`else
            state_d = DIV;
`endif
          end
        end
      end

      MUL: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          result_d = mul_res;
          state_d  = DONE;
        end
      end

      DIV: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          // The last step's outputs go straight into the fix-up so the
          // result is registered on the DIV -> DONE edge.
          if (cnt_q == CNT_W'(1)) begin
            result_d = div_finish(op_q, a_q, b_q, step_quo, step_rem);
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        // start is ignored: it still belongs to the instruction leaving now.
        done    = !bus.flush;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.stall  = stall;
  assign bus.done   = done;
  assign bus.result = result_q;

endmodule
